issue_stage: RTL

ISSUE_STAGE -- requirements
Module: issue_stage

---
 rtl/issue_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/issue_stage.sv
// Dual-issue stage: picks up to two decoded instructions per cycle, tracks long-latency
// destinations in a busy scoreboard and registers the issued slots for the register-file stage.
module issue_stage #(
   parameter int WIDTH_UOP = 8,
   parameter int LOAD_BIT  = WIDTH_UOP - 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [1:0]           in_valid,
   input  logic [WIDTH_UOP-1:0] inA_uop,
   input  logic [4:0]           inA_rd,
   input  logic [4:0]           inA_rj,
   input  logic [4:0]           inA_rk,
   input  logic [31:0]          inA_pc,
   input  logic [31:0]          inA_pc_next,
   input  logic [6:0]           inA_exp,
   input  logic [31:0]          inA_imm,
   input  logic                 inA_wen,
   input  logic [1:0]           inA_cls,
   input  logic [WIDTH_UOP-1:0] inB_uop,
   input  logic [4:0]           inB_rd,
   input  logic [4:0]           inB_rj,
   input  logic [4:0]           inB_rk,
   input  logic [31:0]          inB_pc,
   input  logic [31:0]          inB_pc_next,
   input  logic [6:0]           inB_exp,
   input  logic [31:0]          inB_imm,
   input  logic                 inB_wen,
   input  logic [1:0]           inB_cls,
   output logic [1:0]           pop,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 wb_clr_en,
   input  logic [4:0]           wb_clr_addr,
   output logic                 eu0_en,
   output logic [WIDTH_UOP-1:0] eu0_uop,
   output logic [4:0]           eu0_rd,
   output logic [4:0]           eu0_rj,
   output logic [4:0]           eu0_rk,
   output logic [31:0]          eu0_pc,
   output logic [31:0]          eu0_pc_next,
   output logic [6:0]           eu0_exp,
   output logic [31:0]          eu0_imm,
   output logic                 eu1_en,
   output logic [WIDTH_UOP-1:0] eu1_uop,
   output logic [4:0]           eu1_rd,
   output logic [4:0]           eu1_rj,
   output logic [4:0]           eu1_rk,
   output logic [31:0]          eu1_pc,
   output logic [31:0]          eu1_pc_next,
   output logic [6:0]           eu1_exp,
   output logic [31:0]          eu1_imm
);

   localparam logic [1:0] CLS_ALU    = 2'd0;
   localparam logic [1:0] CLS_MEM    = 2'd1;
   localparam logic [1:0] CLS_BR     = 2'd2;
   localparam logic [1:0] CLS_MULDIV = 2'd3;

   typedef struct packed {
      logic                 en;
      logic [WIDTH_UOP-1:0] uop;
      logic [4:0]           rd;
      logic [4:0]           rj;
      logic [4:0]           rk;
      logic [31:0]          pc;
      logic [31:0]          pc_next;
      logic [6:0]           exp;
      logic [31:0]          imm;
   } euSlot_t;

   logic [31:0] r_busy;
   euSlot_t     r_eu0;
   euSlot_t     r_eu1;

   logic        w_issueA;
   logic        w_issueB;
   logic        w_aWritesRd;
   logic        w_bRawOnA;
   logic        w_sameRd;
   logic        w_aSetsBusy;
   logic [31:0] w_busyNext;
   euSlot_t     w_slotA;
   euSlot_t     w_slotB;

   assign w_slotA = '{en: 1'b1, uop: inA_uop, rd: inA_rd, rj: inA_rj, rk: inA_rk,
                      pc: inA_pc, pc_next: inA_pc_next, exp: inA_exp, imm: inA_imm};
   assign w_slotB = '{en: 1'b1, uop: inB_uop, rd: inB_rd, rj: inB_rj, rk: inB_rk,
                      pc: inB_pc, pc_next: inB_pc_next, exp: inB_exp, imm: inB_imm};

   // Hazard checks look only at the registered scoreboard; busy[0] is always 0 so r0 never blocks.
   always_comb begin
      w_aWritesRd = inA_wen && (inA_rd != 5'd0);
      w_bRawOnA   = w_aWritesRd && ((inB_rj == inA_rd) || (inB_rk == inA_rd));
      w_sameRd    = w_aWritesRd && inB_wen && (inB_rd == inA_rd);
      w_issueA    = rstn && in_valid[0] && !stall && !flush
                    && !r_busy[inA_rj] && !r_busy[inA_rk];
      w_issueB    = w_issueA && in_valid[1] && (inB_cls == CLS_ALU)
                    && !r_busy[inB_rj] && !r_busy[inB_rk]
                    && !w_bRawOnA && (inA_cls != CLS_BR) && !w_sameRd;
   end

   assign pop = w_issueB ? 2'd2 : (w_issueA ? 2'd1 : 2'd0);

   // Loads and mul/div complete late, so their destination stays busy until written back.
   always_comb begin
      w_aSetsBusy = w_issueA && w_aWritesRd
                    && (((inA_cls == CLS_MEM) && inA_uop[LOAD_BIT]) || (inA_cls == CLS_MULDIV));
      w_busyNext  = r_busy;
      if (wb_clr_en) begin
         w_busyNext[wb_clr_addr] = 1'b0;
      end
      if (w_aSetsBusy) begin
         w_busyNext[inA_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         r_busy <= '0;
      end else begin
         r_busy <= {w_busyNext[31:1], 1'b0};
      end
   end

   // Flush beats stall so a redirect always leaves a bubble; stall freezes the issued pair.
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         r_eu0 <= '0;
         r_eu1 <= '0;
      end else if (!stall) begin
         r_eu0 <= w_issueA ? w_slotA : '0;
         r_eu1 <= w_issueB ? w_slotB : '0;
      end
   end

   assign eu0_en      = r_eu0.en;
   assign eu0_uop     = r_eu0.uop;
   assign eu0_rd      = r_eu0.rd;
   assign eu0_rj      = r_eu0.rj;
   assign eu0_rk      = r_eu0.rk;
   assign eu0_pc      = r_eu0.pc;
   assign eu0_pc_next = r_eu0.pc_next;
   assign eu0_exp     = r_eu0.exp;
   assign eu0_imm     = r_eu0.imm;
   assign eu1_en      = r_eu1.en;
   assign eu1_uop     = r_eu1.uop;
   assign eu1_rd      = r_eu1.rd;
   assign eu1_rj      = r_eu1.rj;
   assign eu1_rk      = r_eu1.rk;
   assign eu1_pc      = r_eu1.pc;
   assign eu1_pc_next = r_eu1.pc_next;
   assign eu1_exp     = r_eu1.exp;
   assign eu1_imm     = r_eu1.imm;

endmodule
